// File: rtl/exception_arbiter.sv
// WB-stage precise exception / interrupt arbiter.
// Drives CP0 side-effects, pipeline flush and PC redirect.
module exception_arbiter #(
  parameter int          HW_INT_N     = 6,
  parameter int          SW_INT_N     = 2,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wb_valid,
  input  logic [31:0]         wb_pc,
  input  logic                wb_in_ds,
  input  logic [31:0]         wb_mem_addr,
  input  logic                exc_adel_if,
  input  logic                exc_ri,
  input  logic                exc_ov,
  input  logic                exc_sys,
  input  logic                exc_bp,
  input  logic                exc_adel_ld,
  input  logic                exc_ades,
  input  logic                eret,
  input  logic [HW_INT_N-1:0] hw_int,
  input  logic [SW_INT_N-1:0] sw_int,
  input  logic                status_ie,
  input  logic                status_exl,
  input  logic [7:0]          status_im,
  input  logic [31:0]         cp0_epc,
  output logic                flush,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  output logic                cp0_exc_we,
  output logic [31:0]         epc_out,
  output logic                bd_out,
  output logic [4:0]          exccode_out,
  output logic                badvaddr_we,
  output logic [31:0]         badvaddr_out,
  output logic                exl_clr,
  output logic [HW_INT_N-1:0] cause_ip_hw
);

  localparam int IP_W = HW_INT_N + SW_INT_N;
  localparam int CW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [HW_INT_N-1:0] sync_q [SYNC_STAGES];

  logic [IP_W-1:0] ip_all;
  logic            int_p;
  logic            exc_any;
  logic            take;
  logic            do_eret;
  logic [4:0]      code;
  logic            addr_err;
  logic            bva_pc;

  // Metastability chain on every external interrupt line
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign cause_ip_hw = sync_q[SYNC_STAGES-1];

  assign ip_all  = {cause_ip_hw, sw_int};
  assign int_p   = (|(ip_all & status_im[IP_W-1:0]))
                 & status_ie & !status_exl;
  assign exc_any = exc_adel_if | exc_ri | exc_ov | exc_sys
                 | exc_bp | exc_adel_ld | exc_ades;
  assign take    = (state == IDLE) & wb_valid & (int_p | exc_any);
  assign do_eret = (state == IDLE) & wb_valid & eret & !take;

  always_comb begin
    code     = 5'h00;
    addr_err = 1'b0;
    bva_pc   = 1'b0;
    priority case (1'b1)
      int_p:       code = 5'h00;
      exc_adel_if: begin
        code     = 5'h04;
        addr_err = 1'b1;
        bva_pc   = 1'b1;
      end
      exc_ri:      code = 5'h0A;
      exc_ov:      code = 5'h0C;
      exc_sys:     code = 5'h08;
      exc_bp:      code = 5'h09;
      exc_adel_ld: begin
        code     = 5'h04;
        addr_err = 1'b1;
      end
      exc_ades:    begin
        code     = 5'h05;
        addr_err = 1'b1;
      end
      default:     code = 5'h00;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      cnt            <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      cp0_exc_we     <= 1'b0;
      epc_out        <= '0;
      bd_out         <= 1'b0;
      exccode_out    <= '0;
      badvaddr_we    <= 1'b0;
      badvaddr_out   <= '0;
      exl_clr        <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      cp0_exc_we     <= 1'b0;
      badvaddr_we    <= 1'b0;
      exl_clr        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            epc_out        <= wb_in_ds ? wb_pc - 32'd4 : wb_pc;
            bd_out         <= wb_in_ds;
            exccode_out    <= code;
            badvaddr_out   <= bva_pc ? wb_pc : wb_mem_addr;
            badvaddr_we    <= addr_err;
            cp0_exc_we     <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= EXC_VECTOR;
            flush          <= 1'b1;
            cnt            <= CNT_INIT;
            state          <= FLUSH;
          end else if (do_eret) begin
            exl_clr        <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= cp0_epc;
            flush          <= 1'b1;
            cnt            <= CNT_INIT;
            state          <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            flush <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_arbiter.sv
// Directed vector bench for exception_arbiter.
// Table of single-cycle takes plus multi-cycle corner sequences.
module tb_exception_arbiter;

  localparam logic [6:0] E_IF = 7'b1000000;
  localparam logic [6:0] E_RI = 7'b0100000;
  localparam logic [6:0] E_OV = 7'b0010000;
  localparam logic [6:0] E_SY = 7'b0001000;
  localparam logic [6:0] E_BP = 7'b0000100;
  localparam logic [6:0] E_LD = 7'b0000010;
  localparam logic [6:0] E_ST = 7'b0000001;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_in_ds;
  logic [31:0] wb_mem_addr;
  logic [6:0]  exc_v;
  logic        eret;
  logic [5:0]  hw_int;
  logic [1:0]  sw_int;
  logic        status_ie;
  logic        status_exl;
  logic [7:0]  status_im;
  logic [31:0] cp0_epc;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        cp0_exc_we;
  logic [31:0] epc_out;
  logic        bd_out;
  logic [4:0]  exccode_out;
  logic        badvaddr_we;
  logic [31:0] badvaddr_out;
  logic        exl_clr;
  logic [5:0]  cause_ip_hw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exception_arbiter dut (
    .clk(clk), .resetn(resetn),
    .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_in_ds(wb_in_ds), .wb_mem_addr(wb_mem_addr),
    .exc_adel_if(exc_v[6]), .exc_ri(exc_v[5]),
    .exc_ov(exc_v[4]), .exc_sys(exc_v[3]),
    .exc_bp(exc_v[2]), .exc_adel_ld(exc_v[1]),
    .exc_ades(exc_v[0]), .eret(eret),
    .hw_int(hw_int), .sw_int(sw_int),
    .status_ie(status_ie), .status_exl(status_exl),
    .status_im(status_im), .cp0_epc(cp0_epc),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .cp0_exc_we(cp0_exc_we),
    .epc_out(epc_out), .bd_out(bd_out),
    .exccode_out(exccode_out), .badvaddr_we(badvaddr_we),
    .badvaddr_out(badvaddr_out), .exl_clr(exl_clr),
    .cause_ip_hw(cause_ip_hw)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ds;
    logic [31:0] addr;
    logic [6:0]  exc;
    logic        er;
    logic        valid;
    logic [1:0]  sw;
    logic        ie;
    logic        exl;
    logic [7:0]  im;
    logic [31:0] epc_in;
    logic        x_we;
    logic        x_clr;
    logic [4:0]  x_code;
    logic [31:0] x_epc;
    logic        x_bd;
    logic        x_bvwe;
    logic [31:0] x_bva;
    logic [31:0] x_rpc;
  } vec_t;

  vec_t v [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    wb_valid   = 1'b0;
    exc_v      = '0;
    eret       = 1'b0;
    sw_int     = '0;
    hw_int     = '0;
    status_ie  = 1'b1;
    status_exl = 1'b0;
    status_im  = 8'hFF;
  endtask

  task automatic run_vec(input int n, input vec_t t);
    logic rv;
    rv = t.x_we | t.x_clr;
    @(negedge clk);
    wb_valid    = t.valid;
    wb_pc       = t.pc;
    wb_in_ds    = t.ds;
    wb_mem_addr = t.addr;
    exc_v       = t.exc;
    eret        = t.er;
    sw_int      = t.sw;
    status_ie   = t.ie;
    status_exl  = t.exl;
    status_im   = t.im;
    cp0_epc     = t.epc_in;
    @(posedge clk); #1;
    chk($sformatf("v%0d we", n), 32'(cp0_exc_we), 32'(t.x_we));
    chk($sformatf("v%0d rv", n), 32'(redirect_valid), 32'(rv));
    chk($sformatf("v%0d clr", n), 32'(exl_clr), 32'(t.x_clr));
    chk($sformatf("v%0d bvwe", n), 32'(badvaddr_we), 32'(t.x_bvwe));
    chk($sformatf("v%0d flush", n), 32'(flush), 32'(rv));
    if (rv)
      chk($sformatf("v%0d rpc", n), redirect_pc, t.x_rpc);
    if (t.x_we) begin
      chk($sformatf("v%0d code", n), 32'(exccode_out), 32'(t.x_code));
      chk($sformatf("v%0d epc", n), epc_out, t.x_epc);
      chk($sformatf("v%0d bd", n), 32'(bd_out), 32'(t.x_bd));
      if (t.x_bvwe)
        chk($sformatf("v%0d bva", n), badvaddr_out, t.x_bva);
    end
    clr_in();
    @(posedge clk); #1;
    chk($sformatf("v%0d flush2", n), 32'(flush), 32'(rv));
    chk($sformatf("v%0d pulse2", n), 32'(redirect_valid), 32'(0));
    @(posedge clk); #1;
    chk($sformatf("v%0d flush3", n), 32'(flush), 32'(0));
  endtask

  initial begin
    resetn      = 1'b0;
    wb_pc       = '0;
    wb_in_ds    = 1'b0;
    wb_mem_addr = '0;
    cp0_epc     = '0;
    clr_in();
    hw_int = 6'h3F;
    repeat (3) @(posedge clk);
    #1;
    chk("rst flush", 32'(flush), 32'(0));
    chk("rst rv", 32'(redirect_valid), 32'(0));
    chk("rst rpc", redirect_pc, 32'(0));
    chk("rst we", 32'(cp0_exc_we), 32'(0));
    chk("rst epc", epc_out, 32'(0));
    chk("rst ip", 32'(cause_ip_hw), 32'(0));
    hw_int = '0;
    @(negedge clk);
    resetn = 1'b1;

    //     pc            ds addr  exc          er vl sw  ie exl im     epc_in
    //     we clr code  epc           bd bvwe bva           rpc
    v[0]  = '{32'h80001000, 0, 32'h0, E_OV, 0, 1, 2'b00, 1, 0, 8'hFF, 32'h0,
              1, 0, 5'h0C, 32'h80001000, 0, 0, 32'h0, VEC};
    v[1]  = '{32'h80000008, 1, 32'h1003, E_ST, 0, 1, 2'b00, 1, 0, 8'hFF, 32'h0,
              1, 0, 5'h05, 32'h80000004, 1, 1, 32'h1003, VEC};
    v[2]  = '{32'h80000100, 0, 32'h55, E_IF | E_ST, 0, 1, 2'b00, 1, 0, 8'hFF, 32'h0,
              1, 0, 5'h04, 32'h80000100, 0, 1, 32'h80000100, VEC};
    v[3]  = '{32'h80000200, 0, 32'h0, E_RI | E_OV | E_SY, 0, 1, 2'b00, 1, 0, 8'hFF, 32'h0,
              1, 0, 5'h0A, 32'h80000200, 0, 0, 32'h0, VEC};
    v[4]  = '{32'h80000204, 1, 32'h0, E_SY | E_BP, 0, 1, 2'b00, 1, 0, 8'hFF, 32'h0,
              1, 0, 5'h08, 32'h80000200, 1, 0, 32'h0, VEC};
    v[5]  = '{32'h80000300, 0, 32'h0, E_BP | E_LD, 0, 1, 2'b00, 1, 0, 8'hFF, 32'h0,
              1, 0, 5'h09, 32'h80000300, 0, 0, 32'h0, VEC};
    v[6]  = '{32'h00000000, 1, 32'h2001, E_LD, 0, 1, 2'b00, 1, 0, 8'hFF, 32'h0,
              1, 0, 5'h04, 32'hFFFFFFFC, 1, 1, 32'h2001, VEC};
    v[7]  = '{32'h80000400, 0, 32'h3002, E_LD | E_ST, 0, 1, 2'b00, 1, 0, 8'hFF, 32'h0,
              1, 0, 5'h04, 32'h80000400, 0, 1, 32'h3002, VEC};
    v[8]  = '{32'h80000500, 0, 32'h0, 7'h0, 1, 1, 2'b00, 1, 1, 8'hFF, 32'h80002000,
              0, 1, 5'h00, 32'h0, 0, 0, 32'h0, 32'h80002000};
    v[9]  = '{32'h80000600, 0, 32'h0, E_SY, 1, 1, 2'b00, 1, 0, 8'hFF, 32'h80002000,
              1, 0, 5'h08, 32'h80000600, 0, 0, 32'h0, VEC};
    v[10] = '{32'h80000700, 0, 32'h0, E_OV, 1, 0, 2'b00, 1, 0, 8'hFF, 32'h80002000,
              0, 0, 5'h00, 32'h0, 0, 0, 32'h0, 32'h0};
    v[11] = '{32'h80000800, 0, 32'h0, E_SY, 0, 1, 2'b01, 1, 0, 8'h01, 32'h0,
              1, 0, 5'h00, 32'h80000800, 0, 0, 32'h0, VEC};
    v[12] = '{32'h80000900, 0, 32'h0, 7'h0, 0, 1, 2'b01, 1, 1, 8'hFF, 32'h0,
              0, 0, 5'h00, 32'h0, 0, 0, 32'h0, 32'h0};
    v[13] = '{32'h80000A00, 0, 32'h0, E_RI, 0, 1, 2'b01, 1, 1, 8'hFF, 32'h0,
              1, 0, 5'h0A, 32'h80000A00, 0, 0, 32'h0, VEC};
    v[14] = '{32'h80000B00, 0, 32'h0, 7'h0, 0, 1, 2'b10, 1, 0, 8'h01, 32'h0,
              0, 0, 5'h00, 32'h0, 0, 0, 32'h0, 32'h0};
    v[15] = '{32'h80000C00, 0, 32'h0, 7'h0, 0, 1, 2'b10, 0, 0, 8'h02, 32'h0,
              0, 0, 5'h00, 32'h0, 0, 0, 32'h0, 32'h0};

    for (int i = 0; i < 16; i++)
      run_vec(i, v[i]);

    // hw_int through the synchroniser, outranking a syscall
    @(negedge clk);
    hw_int = 6'b000001;
    @(posedge clk); #1;
    chk("sync 1 edge", 32'(cause_ip_hw), 32'(0));
    @(posedge clk); #1;
    chk("sync 2 edges", 32'(cause_ip_hw), 32'(1));
    @(negedge clk);
    wb_valid = 1'b1;
    wb_pc    = 32'h80003000;
    wb_in_ds = 1'b0;
    exc_v    = E_SY;
    @(posedge clk); #1;
    chk("hwint we", 32'(cp0_exc_we), 32'(1));
    chk("hwint code", 32'(exccode_out), 32'(0));
    chk("hwint epc", epc_out, 32'h80003000);
    wb_valid = 1'b0;
    exc_v    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wb_valid   = 1'b1;
    status_exl = 1'b1;
    @(posedge clk); #1;
    chk("hwint exl we", 32'(cp0_exc_we), 32'(0));
    chk("hwint exl flush", 32'(flush), 32'(0));
    clr_in();
    repeat (3) @(posedge clk);

    // ERET then a fresh exception presented inside FLUSH
    @(negedge clk);
    wb_valid = 1'b1;
    eret     = 1'b1;
    cp0_epc  = 32'h80002000;
    @(posedge clk); #1;
    chk("eret clr", 32'(exl_clr), 32'(1));
    chk("eret rpc", redirect_pc, 32'h80002000);
    chk("eret flush", 32'(flush), 32'(1));
    eret  = 1'b0;
    exc_v = E_OV;
    @(posedge clk); #1;
    chk("inflush we", 32'(cp0_exc_we), 32'(0));
    chk("inflush clr", 32'(exl_clr), 32'(0));
    chk("inflush flush", 32'(flush), 32'(1));
    clr_in();
    @(posedge clk); #1;
    chk("inflush end", 32'(flush), 32'(0));
    chk("inflush we2", 32'(cp0_exc_we), 32'(0));

    // Asynchronous reset mid-FLUSH
    @(negedge clk);
    wb_valid = 1'b1;
    wb_pc    = 32'h80004000;
    exc_v    = E_OV;
    @(posedge clk); #1;
    chk("rstf we", 32'(cp0_exc_we), 32'(1));
    clr_in();
    #1 resetn = 1'b0;
    #1;
    chk("rstf flush", 32'(flush), 32'(0));
    chk("rstf we0", 32'(cp0_exc_we), 32'(0));
    chk("rstf rv", 32'(redirect_valid), 32'(0));
    chk("rstf rpc", redirect_pc, 32'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    wb_valid = 1'b1;
    wb_pc    = 32'h80005000;
    exc_v    = E_RI;
    @(posedge clk); #1;
    chk("post we", 32'(cp0_exc_we), 32'(1));
    chk("post code", 32'(exccode_out), 32'(5'h0A));
    chk("post epc", epc_out, 32'h80005000);
    chk("post flush", 32'(flush), 32'(1));
    clr_in();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
